ifft_frame_ctrl: RTL and testbench



---
 rtl/ifft_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_ifft_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_frame_ctrl.sv
// Frame sequencer for the ifft core: buffers one N-sample frame, bursts it into the core, then counts output beats.
// Optional IFFT_FRAME_BITREV_EN: burst the frame in bit-reversed address order instead of natural order.
module ifft_frame_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              core_en,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_oen,
  input  logic [ADDR_W-1:0] core_oaddr,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  input  logic              err_clr
);

  // Source handshake: a sample transfers on every rising edge where s_valid && s_ready;
  // s_ready is registered and never depends combinationally on s_valid.

  localparam int N  = 1 << ADDR_W;
  localparam int CW = ADDR_W + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] FULL   = CW'(N);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, BURST, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [CW-1:0]     ocnt;
  logic [TW-1:0]     tcnt;
  logic [CW-1:0]     ocnt_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic              oen_in_fill;
  logic              timeout_hit;
  logic              unused_oaddr;

  logic [DATA_W-1:0] ram [0:N-1];

`ifdef IFFT_FRAME_BITREV_EN
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
    return r;
  endfunction
  assign rd_addr = bitrev(rcnt[ADDR_W-1:0]);
`else
  assign rd_addr = rcnt[ADDR_W-1:0];
`endif

  // Output address is observed by the core's consumer, not by this controller.
  assign unused_oaddr = ^core_oaddr;

  assign wr_en       = (state == FILL) && s_valid && s_ready;
  assign ocnt_nxt    = ocnt + CW'(core_oen);
  assign oen_in_fill = (state == FILL) && core_oen;
  assign timeout_hit = (state == DRAIN) && (ocnt_nxt < FULL) && (tcnt == T_LAST);
  assign busy        = (state == BURST) || (state == DRAIN);

  always_ff @(posedge iclk) begin
    if (wr_en) ram[wcnt[ADDR_W-1:0]] <= s_data;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wcnt       <= '0;
      rcnt       <= '0;
      ocnt       <= '0;
      tcnt       <= '0;
      s_ready    <= 1'b0;
      core_en    <= 1'b0;
      core_addr  <= '0;
      core_data  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A new error event wins over a simultaneous clear.
      err        <= (err && !err_clr) || oen_in_fill || timeout_hit;
      // Read data, enable and address all emerge together one cycle after the read.
      core_en    <= (state == BURST);
      if (state == BURST) begin
        core_addr <= rd_addr;
        core_data <= ram[rd_addr];
      end

      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (wr_en) begin
            if (wcnt == LAST) begin
              wcnt    <= '0;
              rcnt    <= '0;
              s_ready <= 1'b0;
              state   <= BURST;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        BURST: begin
          s_ready <= 1'b0;
          ocnt    <= ocnt_nxt;
          if (rcnt == LAST) begin
            rcnt  <= '0;
            tcnt  <= '0;
            state <= DRAIN;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
        DRAIN: begin
          if (ocnt_nxt >= FULL) begin
            frame_done <= 1'b1;
            ocnt       <= '0;
            tcnt       <= '0;
            s_ready    <= 1'b1;
            state      <= FILL;
          end else if (tcnt == T_LAST) begin
            ocnt    <= '0;
            tcnt    <= '0;
            s_ready <= 1'b1;
            state   <= FILL;
          end else begin
            s_ready <= 1'b0;
            ocnt    <= ocnt_nxt;
            tcnt    <= tcnt + TW'(1);
          end
        end
        default: begin
          s_ready <= 1'b0;
          state   <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Bench for ifft_frame_ctrl with N=8, TIMEOUT=16: frame scoreboard on the burst plus directed timing checks.
// Honours IFFT_FRAME_BITREV_EN to select the expected burst order.
module tb_ifft_frame_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int TO = 16;

  logic          iclk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          core_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_data;
  logic          core_oen;
  logic [AW-1:0] core_oaddr;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic          err_clr;

  ifft_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .iclk(iclk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_en(core_en), .core_addr(core_addr), .core_data(core_data),
    .core_oen(core_oen), .core_oaddr(core_oaddr), .busy(busy),
    .frame_done(frame_done), .err(err), .err_clr(err_clr)
  );

  // clock / reset
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int en_run   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    seen_addr[$];
  logic [DW-1:0]    seen_data[$];

`ifdef IFFT_FRAME_BITREV_EN
  int lit[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int lit[N] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the k-th beat of a burst carries RAM address ord(k).
  function automatic int ord(input int k);
`ifdef IFFT_FRAME_BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++) if (k[b]) r = r | (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  // scoreboard / monitor
  always @(negedge iclk) begin
    if (rst) begin
      exp_q.delete();
      en_run = 0;
    end else begin
      if (core_en) begin
        en_run++;
        chk("busy_during_en", busy, 1);
        chk("burst_beat_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("burst_beat", {core_addr, core_data}, exp_q.pop_front());
          seen_addr.push_back(core_addr);
          seen_data.push_back(core_data);
        end
      end else if (en_run != 0) begin
        chk("burst_len", en_run, N);
        en_run = 0;
      end
      if (frame_done) done_cnt++;
    end
  end

  // drivers
  task automatic send_frame(input int base, input bit gappy, input int poke);
    for (int i = 0; i < N; i++) begin
      if (gappy) begin
        @(negedge iclk);
        s_valid = 1'b0;
        s_data  = 32'hdead_beef;
        chk("ready_gap", s_ready, 1);
      end
      if (i == poke) begin
        @(negedge iclk);
        s_valid  = 1'b0;
        core_oen = 1'b1;
        @(negedge iclk);
        core_oen = 1'b0;
        chk("err_fill_oen", err, 1);
        chk("ready_after_poke", s_ready, 1);
      end
      @(negedge iclk);
      chk("ready_fill", s_ready, 1);
      s_valid = 1'b1;
      s_data  = DW'(base + i);
    end
    @(negedge iclk);
    s_valid = 1'b0;
    chk("ready_drop", s_ready, 0);
    chk("busy_burst", busy, 1);
    for (int k = 0; k < N; k++) exp_q.push_back({AW'(ord(k)), DW'(base + ord(k))});
  endtask

  task automatic wait_en(input logic lvl, input string name);
    int k = 0;
    do begin
      @(negedge iclk);
      k++;
    end while (core_en !== lvl && k < 40);
    chk(name, core_en, lvl);
  endtask

  task automatic drain_frame();
    wait_en(1'b1, "en_rise");
    wait_en(1'b0, "en_fall");
    for (int k = 0; k < N; k++) begin
      core_oen   = 1'b1;
      core_oaddr = AW'(k);
      @(negedge iclk);
    end
    core_oen = 1'b0;
    exp_done++;
    chk("done_pulse", frame_done, 1);
    chk("ready_after_done", s_ready, 1);
    chk("idle_after_done", busy, 0);
    @(negedge iclk);
    chk("done_one_cycle", frame_done, 0);
    chk("done_count", done_cnt, exp_done);
  endtask

  task automatic pulse_clr(input logic with_oen);
    @(negedge iclk);
    err_clr  = 1'b1;
    core_oen = with_oen;
    @(negedge iclk);
    err_clr  = 1'b0;
    core_oen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    core_oen = 1'b0; core_oaddr = '0; err_clr = 1'b0;

    // reset state
    @(negedge iclk);
    @(negedge iclk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_addr", core_addr, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge iclk);
    chk("ready_after_rst", s_ready, 1);

    // natural stream 0..7, pinned against the literal order table
    seen_addr.delete();
    seen_data.delete();
    send_frame(0, 1'b0, -1);
    drain_frame();
    chk("seen_cnt", seen_addr.size(), N);
    for (int k = 0; k < N && k < seen_addr.size(); k++) begin
      chk("addr_lit", seen_addr[k], lit[k]);
      chk("data_lit", seen_data[k], lit[k]);
    end

    // s_valid toggling 1,0,1,0
    send_frame(32'h10, 1'b1, -1);
    drain_frame();

    // drain timeout: only 5 output beats
    send_frame(32'h20, 1'b0, -1);
    wait_en(1'b1, "to_en_rise");
    for (int idx = 1; idx <= 24; idx++) begin
      @(negedge iclk);
      if (idx == 22) begin
        chk("to_err_pre", err, 0);
        chk("to_busy_pre", busy, 1);
      end
      if (idx == 23) begin
        chk("to_err", err, 1);
        chk("to_ready", s_ready, 1);
        chk("to_busy", busy, 0);
      end
      core_oen = (idx >= 8 && idx <= 12);
    end
    core_oen = 1'b0;
    chk("to_no_done", done_cnt, exp_done);
    pulse_clr(1'b0);
    chk("to_err_clr", err, 0);

    // stray core_oen while filling
    send_frame(32'h30, 1'b0, 3);
    chk("err_sticky", err, 1);
    drain_frame();
    pulse_clr(1'b1);
    chk("err_clr_vs_event", err, 1);
    pulse_clr(1'b0);
    chk("err_clr_fill", err, 0);
    chk("ready_fill_idle", s_ready, 1);

    // reset in the 4th burst cycle
    send_frame(32'h40, 1'b0, -1);
    wait_en(1'b1, "mid_en_rise");
    @(negedge iclk);
    @(negedge iclk);
    rst = 1'b1;
    #1;
    chk("mid_rst_core_en", core_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    @(negedge iclk);
    @(negedge iclk);
    rst = 1'b0;
    @(negedge iclk);
    chk("mid_rst_ready_rise", s_ready, 1);
    chk("mid_rst_err", err, 0);
    send_frame(32'h50, 1'b0, -1);
    drain_frame();

    @(negedge iclk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("final_done_count", done_cnt, exp_done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
